// File: rtl/div_pkg.sv
// Shared types and defaults for the reciprocal-multiply divider.
// Holds width defaults, counter width and the FSM state type.
package div_pkg;

  localparam int ARG_BIT_WIDTH_DEF = 32;
  localparam int PRECISION_DEF     = 64;
  localparam int CNT_W_DEF         = $clog2(PRECISION_DEF) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
`ifdef QUOTIENT_CORRECT_EN
    S_CORR = 3'd2,
    S_FIX  = 3'd3,
`endif
    S_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/seq_shift_add_step.sv
// One shift-add multiply step: sum = acc + (sel ? addend : 0).
// Ports: acc, addend (WIDTH), sel (1) in; sum (WIDTH) out.
module seq_shift_add_step
  import div_pkg::*;
#(
  parameter int WIDTH = ARG_BIT_WIDTH_DEF + PRECISION_DEF
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] addend,
  input  logic             sel,
  output logic [WIDTH-1:0] sum
);

  assign sum = acc + (sel ? addend : '0);

endmodule

// File: rtl/sequential_quotient_multiplier.sv
// Quotient = dividend * reciprocal >> (PRECISION-1), one bit per clock.
// Ports: clk, rst_n, start, dividend, divisor, reciprocal, dvz_in in;
// quotient, remainder, done, dvz out.
// Macro QUOTIENT_CORRECT_EN adds the remainder/quotient fix-up pass;
// without it remainder is tied to zero.
module sequential_quotient_multiplier
  import div_pkg::*;
#(
  parameter int ARG_BIT_WIDTH = ARG_BIT_WIDTH_DEF,
  parameter int PRECISION     = PRECISION_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ARG_BIT_WIDTH-1:0] dividend,
  input  logic [ARG_BIT_WIDTH-1:0] divisor,
  input  logic [PRECISION-1:0]     reciprocal,
  input  logic                     dvz_in,
  output logic [ARG_BIT_WIDTH-1:0] quotient,
  output logic [ARG_BIT_WIDTH-1:0] remainder,
  output logic                     done,
  output logic                     dvz
);

  localparam int W  = ARG_BIT_WIDTH;
  localparam int PW = ARG_BIT_WIDTH + PRECISION;
  localparam int CW = $clog2(PRECISION) + 1;

  div_state_e      state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [PRECISION-1:0] mplier;
  logic [W-1:0]    q_q;
  logic            done_q;
  logic            dvz_q;
  logic [PW-1:0]   sum;
  logic [W-1:0]    est;

  seq_shift_add_step #(
    .WIDTH (PW)
  ) u_step (
    .acc    (acc),
    .addend (mcand),
    .sel    (mplier[0]),
    .sum    (sum)
  );

  // Reciprocal is scaled by 2^(PRECISION-1).
  assign est = acc[PW-2:PRECISION-1];

`ifdef QUOTIENT_CORRECT_EN
  logic [W-1:0] dvd_q;
  logic [W-1:0] dvs_q;
  logic [W-1:0] est_q;
  logic [W-1:0] rem_q;
  logic [W-1:0] r;
  logic         r_ge;

  // Estimate is exact or one low, so r < 2*divisor and r <= dividend.
  assign r    = dvd_q - acc[W-1:0];
  assign r_ge = (r >= dvs_q);
  assign remainder = rem_q;
`else
  logic unused_divisor;
  assign unused_divisor = ^divisor;
  assign remainder = '0;
`endif

  assign quotient = q_q;
  assign done     = done_q;
  assign dvz      = dvz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      q_q    <= '0;
      done_q <= 1'b0;
      dvz_q  <= 1'b0;
`ifdef QUOTIENT_CORRECT_EN
      dvd_q  <= '0;
      dvs_q  <= '0;
      est_q  <= '0;
      rem_q  <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc    <= '0;
            cnt    <= '0;
            mcand  <= PW'(dividend);
            mplier <= reciprocal;
            done_q <= 1'b0;
            dvz_q  <= dvz_in;
`ifdef QUOTIENT_CORRECT_EN
            dvd_q  <= dividend;
            dvs_q  <= divisor;
`endif
            if (dvz_in) begin
              q_q   <= '1;
`ifdef QUOTIENT_CORRECT_EN
              rem_q <= dividend;
`endif
              state <= S_DONE;
            end else begin
              state <= S_MUL;
            end
          end else if (state == S_DONE && !done_q) begin
            // Divide-by-zero result shows one edge after accept.
            done_q <= 1'b1;
          end
        end
        S_MUL: begin
          if (cnt == CW'(PRECISION)) begin
`ifdef QUOTIENT_CORRECT_EN
            est_q  <= est;
            acc    <= '0;
            mcand  <= PW'(est);
            mplier <= PRECISION'(dvs_q);
            cnt    <= '0;
            state  <= S_CORR;
`else
            q_q    <= est;
            done_q <= 1'b1;
            state  <= S_DONE;
`endif
          end else begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
`ifdef QUOTIENT_CORRECT_EN
        S_CORR: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (r_ge) begin
            q_q   <= est_q + W'(1);
            rem_q <= r - dvs_q;
          end else begin
            q_q   <= est_q;
            rem_q <= r;
          end
          done_q <= 1'b1;
          state  <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_quotient_multiplier.sv
// Randomized and directed bench for sequential_quotient_multiplier.
// Results and latency are checked against an arithmetic reference.
module tb_sequential_quotient_multiplier;

  localparam int W = 32;
  localparam int P = 64;
`ifdef QUOTIENT_CORRECT_EN
  localparam int LAT = P + W + 2;
`else
  localparam int LAT = P + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [P-1:0]  reciprocal = '0;
  logic          dvz_in = 1'b0;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          done;
  logic          dvz;

  int n_tests = 0;
  int n_fail  = 0;

  sequential_quotient_multiplier #(
    .ARG_BIT_WIDTH (W),
    .PRECISION     (P)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .reciprocal (reciprocal),
    .dvz_in     (dvz_in),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .dvz        (dvz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] recip(input logic [W-1:0] d);
    logic [63:0] one = 64'h8000_0000_0000_0000;
    return one / {32'b0, d};
  endfunction

  // Reference: exact division with correction, truncated
  // reciprocal product without it.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] d,
                       input logic [P-1:0] r, input bit z,
                       output logic [W-1:0] eq, output logic [W-1:0] er);
    logic [127:0] prod;
    if (z) begin
      eq = '1;
`ifdef QUOTIENT_CORRECT_EN
      er = a;
`else
      er = '0;
`endif
    end else begin
`ifdef QUOTIENT_CORRECT_EN
      eq = a / d;
      er = a % d;
`else
      prod = {96'b0, a} * {64'b0, r};
      prod = prod >> 63;
      eq = prod[W-1:0];
      er = '0;
`endif
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] d,
                       input logic [P-1:0] r, input bit z,
                       input int pulse_at, input int rst_at);
    logic [W-1:0] eq, er;
    int n;
    bit aborted;
    model(a, d, r, z, eq, er);
    @(negedge clk);
    dividend = a; divisor = d; reciprocal = r; dvz_in = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_clr", 64'(done), 64'd0);
    n = 0;
    aborted = 0;
    while (!done && n < 300 && !aborted) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == pulse_at) begin
        dividend = $urandom; divisor = 32'd3;
        reciprocal = recip(32'd3); dvz_in = $urandom_range(0, 1);
        start = 1'b1;
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_rem", 64'(remainder), 64'd0);
        chk("rst_dvz", 64'(dvz), 64'd0);
        repeat (2) @(posedge clk);
        #1 chk("rst_hold", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("latency", 64'(n), z ? 64'd1 : 64'(LAT));
      chk("quotient", 64'(quotient), 64'(eq));
      chk("remainder", 64'(remainder), 64'(er));
      chk("dvz", 64'(dvz), 64'(z));
      repeat (3) @(posedge clk);
      #1;
      chk("hold_done", 64'(done), 64'd1);
      chk("hold_q", 64'(quotient), 64'(eq));
    end
  endtask

  initial begin
    logic [W-1:0] a, d;
    #1;
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_q", 64'(quotient), 64'd0);
    chk("reset_rem", 64'(remainder), 64'd0);
    chk("reset_dvz", 64'(dvz), 64'd0);
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'd100, 32'd7, recip(32'd7), 0, -1, -1);
    do_op(32'd3, 32'd3, 64'h2AAA_AAAA_AAAA_AAAA, 0, -1, -1);
    do_op(32'hFFFF_FFFF, 32'd1, 64'h8000_0000_0000_0000, 0, -1, -1);
    do_op(32'd5, 32'd0, 64'd0, 1, -1, -1);
    do_op(32'd100, 32'd7, recip(32'd7), 0, 10, -1);
    do_op(32'd12345, 32'd11, recip(32'd11), 0, -1, 30);
    do_op(32'd12345, 32'd11, recip(32'd11), 0, -1, -1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, recip(32'hFFFF_FFFF), 0, -1, -1);
    do_op(32'd0, 32'd9, recip(32'd9), 0, -1, -1);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      d = (i % 3 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (d == 0) d = 1;
      do_op(a, d, recip(d), ($urandom_range(0, 7) == 0), -1, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sequential_quotient_multiplier.md
SEQUENTIAL_QUOTIENT_MULTIPLIER -- requirements
Module: sequential_quotient_multiplier

Interface
REQ-001 SHALL have parameter ARG_BIT_WIDTH, default 32, width of dividend, divisor and quotient.
REQ-002 SHALL have parameter PRECISION, default 64, width of the reciprocal input.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE or DONE.
REQ-006 SHALL have port dividend  input  ARG_BIT_WIDTH  numerator, captured on accepted start.
REQ-007 SHALL have port divisor  input  ARG_BIT_WIDTH  denominator, captured on accepted start.
REQ-008 SHALL have port reciprocal  input  PRECISION  floor(2^(PRECISION-1)/divisor) from the upstream reciprocal stage, captured on accepted start.
REQ-009 SHALL have port dvz_in  input  1  upstream divide-by-zero flag, captured on accepted start.
REQ-010 SHALL have port quotient  output  ARG_BIT_WIDTH  result.
REQ-011 SHALL have port remainder  output  ARG_BIT_WIDTH  result remainder (see Configuration).
REQ-012 SHALL have port done  output  1  level, high while results are valid.
REQ-013 SHALL have port dvz  output  1  registered copy of captured dvz_in.

Function
REQ-014 SHALL implement states IDLE, MUL, CORR, FIX, DONE; CORR and FIX exist only with QUOTIENT_CORRECT_EN.
REQ-015 IDLE/DONE + start=1 SHALL capture all inputs, clear the accumulator, clear done, enter MUL (or DONE directly if dvz_in=1).
REQ-016 start while in MUL, CORR or FIX SHALL be ignored; inputs are not re-captured.
REQ-017 MUL SHALL run exactly PRECISION cycles, one shift-add per cycle on one reciprocal bit, LSB first, into an (ARG_BIT_WIDTH+PRECISION)-bit product register; no overflow possible.
REQ-018 Estimated quotient SHALL be product[ARG_BIT_WIDTH+PRECISION-2 : PRECISION-1]; it equals the true quotient or true quotient minus 1.
REQ-019 Without correction, MUL exit SHALL load quotient with the estimate, remainder with 0, and enter DONE; done rises PRECISION+1 edges after the accepting edge.
REQ-020 With correction, CORR SHALL compute estimate*divisor in ARG_BIT_WIDTH shift-add cycles (lower ARG_BIT_WIDTH bits kept); FIX (1 cycle) SHALL form r = dividend - product; if r >= divisor then quotient = estimate+1, remainder = r-divisor, else quotient = estimate, remainder = r; done rises PRECISION+ARG_BIT_WIDTH+2 edges after the accepting edge.
REQ-021 dvz_in=1 at accept SHALL give quotient all-ones, remainder = dividend, dvz=1, done high one edge after accept.
REQ-022 In DONE, quotient, remainder, dvz and done SHALL hold until the next accepted start; start in DONE begins a new operation on that edge (back-to-back allowed).
REQ-023 divisor=0 with dvz_in=0 is illegal; result unspecified, FSM SHALL still return to DONE within normal latency.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, done=0, dvz=0, quotient=0, remainder=0, accumulator and counter 0, including mid-operation; the aborted operation produces no done.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro QUOTIENT_CORRECT_EN defined: CORR/FIX states and the correction datapath compiled in per REQ-020; undefined: states absent, remainder tied 0, behaviour per REQ-019.

Structure
REQ-027 Shared package div_pkg SHALL hold ARG_BIT_WIDTH, PRECISION defaults, counter width $clog2(PRECISION)+1, and the state enum typedef.
REQ-028 One sub-module seq_shift_add_step (combinational one-bit shift-add) SHALL be reused by MUL and CORR; FSM and registers stay in the top module.

Verification
REQ-029 dividend=100, divisor=7, reciprocal=floor(2^63/7), dvz_in=0 -> quotient=14, remainder=2 (macro on), done at edge 98.
REQ-030 dividend=3, divisor=3, reciprocal=0x2AAAAAAAAAAAAAAA -> macro off: quotient=0 at edge 65; macro on: quotient=1, remainder=0.
REQ-031 dividend=0xFFFFFFFF, divisor=1, reciprocal=2^63 -> quotient=0xFFFFFFFF, remainder=0.
REQ-032 dvz_in=1, dividend=5 -> next edge: done=1, dvz=1, quotient=0xFFFFFFFF, remainder=5.
REQ-033 start re-pulsed with new operands at cycle 10 of MUL -> ignored, original result delivered at normal latency.
REQ-034 rst_n low at cycle 30 of MUL -> all outputs 0 immediately, IDLE; a fresh start afterwards completes correctly.
